// File: rtl/int_ctrl18_if.sv
// Core18 interrupt-controller bus: request lines, core handshake and port bus.
// The controller sits on the slave side; the core (or a bench) drives the master side.
interface int_ctrl18_if;
  logic [14:0] IRQ;
  logic        INT_ACK;
  logic        RTI_DONE;
  logic        PORT_WR;
  logic        PORT_RD;
  logic [17:0] ADRS;
  logic [17:0] DATAOUT;
  logic [3:0]  VECTOR;
  logic [17:0] RDATA;
  logic        INT_PEND;

  modport master (
    output IRQ, INT_ACK, RTI_DONE, PORT_WR, PORT_RD, ADRS, DATAOUT,
    input  VECTOR, RDATA, INT_PEND
  );

  modport slave (
    input  IRQ, INT_ACK, RTI_DONE, PORT_WR, PORT_RD, ADRS, DATAOUT,
    output VECTOR, RDATA, INT_PEND
  );
endinterface

// File: rtl/int_ctrl18.sv
// Prioritised, nesting interrupt controller for the Core18 VECTOR input.
// Latches rising edges on IRQ, presents the highest eligible vector until the
// core acknowledges it, and tracks in-service levels until RTI.
module int_ctrl18 #(
  parameter int          NUM_SRC   = 15,
  parameter logic [17:0] BASE_ADRS = 18'o0770
) (
  input logic        CLK,
  input logic        RESET_N,
  int_ctrl18_if.slave bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRESENT = 2'd1;
  localparam logic [1:0] ST_GAP     = 2'd2;

  // Sources beyond NUM_SRC are tied off so they can never raise a request.
  localparam logic [14:0] SRC_MASK = 15'((32'd1 << NUM_SRC) - 32'd1);

  logic [1:0]  state_q,    state_d;
  logic [3:0]  vector_q,   vector_d;
  logic [14:0] mask_q,     mask_d;
  logic [14:0] pend_q,     pend_d;
  logic [14:0] insvc_q,    insvc_d;
  logic [14:0] irq_prev_q, irq_prev_d;
  logic        gie_q,      gie_d;

  logic [14:0] irq_in;
  logic [14:0] edges;
  logic [3:0]  lvl_q;
  logic [14:0] eligible;
  logic [3:0]  winner;
  logic [17:0] offset;
  logic        hit;
  logic [1:0]  reg_sel;
  logic        wr_mask, wr_pend, wr_ctrl;
  logic        ack_take;
  logic [14:0] ack_bit;
  logic [14:0] rti_bit;
  logic [14:0] cur_bit;
  logic        still_ok;
  logic [17:0] rdata;
  logic        unused_dataout;

  // Highest vector number whose bit is set (bit i = vector i+1), 0 if none.
  function automatic logic [3:0] top_vec(input logic [14:0] bits);
    top_vec = 4'd0;
    for (int i = 0; i < 15; i++) begin
      if (bits[i]) top_vec = 4'(i + 1);
    end
  endfunction

  // Bits whose vector number is strictly above the given level.
  function automatic logic [14:0] above(input logic [3:0] lvl);
    above = '0;
    for (int i = 0; i < 15; i++) begin
      above[i] = ((i + 1) > int'(lvl));
    end
  endfunction

  assign unused_dataout = ^bus.DATAOUT[17:15];

  // Address decode; addresses below the base wrap to a large offset and miss.
  assign offset  = bus.ADRS - BASE_ADRS;
  assign hit     = (offset < 18'd4);
  assign reg_sel = offset[1:0];

  // Register next-state: port writes, request latching, in-service bookkeeping.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    irq_in   = bus.IRQ & SRC_MASK;
    edges    = irq_in & ~irq_prev_q;
    lvl_q    = top_vec(insvc_q);
    eligible = pend_q & mask_q & {15{gie_q}} & above(lvl_q);
    winner   = top_vec(eligible);

    wr_mask  = bus.PORT_WR && hit && (reg_sel == 2'd0);
    wr_pend  = bus.PORT_WR && hit && (reg_sel == 2'd1);
    wr_ctrl  = bus.PORT_WR && hit && (reg_sel == 2'd3);

    ack_take = (state_q == ST_PRESENT) && bus.INT_ACK;
    cur_bit  = 15'd1 << (vector_q - 4'd1);
    ack_bit  = ack_take ? cur_bit : '0;
    rti_bit  = (bus.RTI_DONE && (insvc_q != '0)) ? (15'd1 << (lvl_q - 4'd1)) : '0;

    irq_prev_d = irq_in;
    mask_d     = wr_mask ? bus.DATAOUT[14:0] : mask_q;
    gie_d      = wr_ctrl ? bus.DATAOUT[0] : gie_q;
    // A fresh edge beats both the W1C and the acknowledge clear.
    pend_d     = (pend_q & ~(wr_pend ? bus.DATAOUT[14:0] : 15'd0) & ~ack_bit) | edges;
    // RTI retires the prior level before the acknowledged vector is pushed.
    insvc_d    = (insvc_q & ~rti_bit) | ack_bit;

    // The presented vector is re-qualified against the post-edge register values,
    // so a mask/W1C/GIE write withdraws it on the very next cycle.
    still_ok = |(pend_d & mask_d & {15{gie_d}} & above(top_vec(insvc_d)) & cur_bit);
  end

  // Presentation FSM: IDLE picks a winner, PRESENT holds it, GAP forces one zero cycle.
  always_comb begin
    state_d  = state_q;
    vector_d = vector_q;
    case (state_q)
      ST_IDLE: begin
        vector_d = 4'd0;
        if (winner != 4'd0) begin
          state_d  = ST_PRESENT;
          vector_d = winner;
        end
      end
      ST_PRESENT: begin
        if (ack_take) begin
          state_d  = ST_GAP;
          vector_d = 4'd0;
        end else if (!still_ok) begin
          state_d  = ST_IDLE;
          vector_d = 4'd0;
        end
      end
      ST_GAP: begin
        state_d  = ST_IDLE;
        vector_d = 4'd0;
      end
      default: begin
        state_d  = ST_IDLE;
        vector_d = 4'd0;
      end
    endcase
  end

  // Read mux: shows the current (pre-write) register contents while PORT_RD hits.
  always_comb begin
    rdata = '0;
    if (bus.PORT_RD && hit) begin
      case (reg_sel)
        2'd0:    rdata = {3'b000, mask_q};
        2'd1:    rdata = {3'b000, pend_q};
        2'd2:    rdata = {3'b000, insvc_q};
        default: rdata = {17'd0, gie_q};
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!RESET_N) begin
      state_q    <= ST_IDLE;
      vector_q   <= 4'd0;
      mask_q     <= '0;
      pend_q     <= '0;
      insvc_q    <= '0;
      irq_prev_q <= '0;
      gie_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      vector_q   <= vector_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      insvc_q    <= insvc_d;
      irq_prev_q <= irq_prev_d;
      gie_q      <= gie_d;
    end
  end

  assign bus.VECTOR   = vector_q;
  assign bus.RDATA    = rdata;
  assign bus.INT_PEND = |eligible;

endmodule

// File: tb/tb_int_ctrl18.sv
// Self-checking bench for int_ctrl18: directed scenarios plus a randomized run
// compared against a behavioural model built on a vector stack and plain arithmetic.
module tb_int_ctrl18;

  localparam logic [17:0] BASE = 18'o0770;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int_ctrl18_if bus();

  int_ctrl18 #(.NUM_SRC(15), .BASE_ADRS(BASE)) dut (
    .CLK    (clk),
    .RESET_N(rst_n),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // ---------------- behavioural model ----------------
  logic [14:0] m_mask, m_pend, m_prev;
  logic        m_gie;
  int          m_stack[$];   // vectors currently in service, in entry order
  int          m_vec;        // vector shown to the core, 0 = none
  bit          m_gap;        // forced zero cycle after an acknowledge
  int          m_pick, m_idx, m_max;
  bit          m_acked, m_ok;
  logic [17:0] m_off;

  function automatic int m_level();
    int lv = 0;
    foreach (m_stack[i]) if (m_stack[i] > lv) lv = m_stack[i];
    return lv;
  endfunction

  function automatic int m_best(logic [14:0] p, logic [14:0] m, logic g, int lvl);
    for (int v = 15; v > lvl; v--) if (g && p[v-1] && m[v-1]) return v;
    return 0;
  endfunction

  function automatic logic [14:0] m_insvc();
    logic [14:0] b = '0;
    foreach (m_stack[i]) b[m_stack[i]-1] = 1'b1;
    return b;
  endfunction

  function automatic logic [17:0] m_read(logic [17:0] a);
    logic [17:0] o = a - BASE;
    if (o >= 18'd4) return 18'd0;
    case (o[1:0])
      2'd0:    return {3'b000, m_mask};
      2'd1:    return {3'b000, m_pend};
      2'd2:    return {3'b000, m_insvc()};
      default: return {17'd0, m_gie};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_mask = '0; m_pend = '0; m_prev = '0; m_gie = 1'b0;
      m_stack.delete(); m_vec = 0; m_gap = 0;
    end else begin
      m_pick  = m_best(m_pend, m_mask, m_gie, m_level());
      m_acked = (m_vec != 0) && bus.INT_ACK;
      m_off   = bus.ADRS - BASE;
      if (bus.PORT_WR && m_off == 18'd1) m_pend = m_pend & ~bus.DATAOUT[14:0];
      if (m_acked) m_pend[m_vec-1] = 1'b0;
      m_pend = m_pend | (bus.IRQ & ~m_prev);
      if (bus.PORT_WR && m_off == 18'd0) m_mask = bus.DATAOUT[14:0];
      if (bus.PORT_WR && m_off == 18'd3) m_gie = bus.DATAOUT[0];
      if (bus.RTI_DONE && m_stack.size() > 0) begin
        m_idx = 0; m_max = 0;
        foreach (m_stack[i]) if (m_stack[i] > m_max) begin m_max = m_stack[i]; m_idx = i; end
        m_stack.delete(m_idx);
      end
      if (m_acked) m_stack.push_back(m_vec);
      m_prev = bus.IRQ;
      if (m_gap) begin
        m_gap = 0;
      end else if (m_vec != 0) begin
        m_ok = m_gie && m_pend[m_vec-1] && m_mask[m_vec-1] && (m_vec > m_level());
        if (m_acked) begin m_vec = 0; m_gap = 1; end
        else if (!m_ok) m_vec = 0;
      end else begin
        m_vec = m_pick;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic port_write(input int off, input logic [17:0] data);
    bus.PORT_WR = 1'b1; bus.ADRS = BASE + 18'(off); bus.DATAOUT = data;
    tick();
    bus.PORT_WR = 1'b0; bus.ADRS = '0; bus.DATAOUT = '0;
  endtask

  task automatic port_read(input int off, output logic [17:0] d);
    bus.PORT_RD = 1'b1; bus.ADRS = BASE + 18'(off);
    #1;
    d = bus.RDATA;
    bus.PORT_RD = 1'b0; bus.ADRS = '0;
  endtask

  task automatic pulse_irq(input logic [14:0] bits);
    bus.IRQ = bits; tick(); bus.IRQ = '0;
  endtask

  task automatic do_ack();
    bus.INT_ACK = 1'b1; tick(); bus.INT_ACK = 1'b0;
  endtask

  task automatic do_rti();
    bus.RTI_DONE = 1'b1; tick(); bus.RTI_DONE = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [17:0] d;
    rst_n = 1'b0;
    repeat (3) tick();
    n_total++; if (bus.VECTOR !== 4'd0) $display("FAIL reset_vector act=%0d exp=0", bus.VECTOR); else n_pass++;
    n_total++; if (bus.INT_PEND !== 1'b0) $display("FAIL reset_int_pend act=%0b exp=0", bus.INT_PEND); else n_pass++;
    n_total++; if (bus.RDATA !== 18'd0) $display("FAIL reset_rdata act=%h exp=0", bus.RDATA); else n_pass++;
    rst_n = 1'b1;
    for (int off = 0; off < 4; off++) begin
      port_read(off, d);
      n_total++; if (d !== 18'd0) $display("FAIL reset_reg%0d act=%h exp=0", off, d); else n_pass++;
    end
  endtask

  task automatic test_basic();
    logic [17:0] d;
    port_write(0, 18'h00010);
    port_write(3, 18'h00001);
    bus.IRQ = 15'h0010; tick(); bus.IRQ = '0;
    n_total++; if (bus.VECTOR !== 4'd0) $display("FAIL basic_one_edge act=%0d exp=0", bus.VECTOR); else n_pass++;
    tick();
    n_total++; if (bus.VECTOR !== 4'd5) $display("FAIL basic_two_edges act=%0d exp=5", bus.VECTOR); else n_pass++;
    n_total++; if (bus.INT_PEND !== 1'b1) $display("FAIL basic_int_pend act=%0b exp=1", bus.INT_PEND); else n_pass++;
    repeat (3) begin
      tick();
      n_total++; if (bus.VECTOR !== 4'd5) $display("FAIL basic_hold act=%0d exp=5", bus.VECTOR); else n_pass++;
    end
    do_ack();
    n_total++; if (bus.VECTOR !== 4'd0) $display("FAIL basic_gap act=%0d exp=0", bus.VECTOR); else n_pass++;
    port_read(1, d);
    n_total++; if (d !== 18'd0) $display("FAIL basic_pend act=%h exp=0", d); else n_pass++;
    port_read(2, d);
    n_total++; if (d !== 18'h00010) $display("FAIL basic_insvc act=%h exp=00010", d); else n_pass++;
    tick();
    n_total++; if (bus.VECTOR !== 4'd0) $display("FAIL basic_after_gap act=%0d exp=0", bus.VECTOR); else n_pass++;
  endtask

  task automatic test_nesting();
    logic [17:0] d;
    port_write(0, 18'h00214);
    pulse_irq(15'h0200);
    tick();
    n_total++; if (bus.VECTOR !== 4'd10) $display("FAIL nest_vec10 act=%0d exp=10", bus.VECTOR); else n_pass++;
    do_ack();
    port_read(2, d);
    n_total++; if (d !== 18'h00210) $display("FAIL nest_insvc2 act=%h exp=00210", d); else n_pass++;
    do_rti();
    port_read(2, d);
    n_total++; if (d !== 18'h00010) $display("FAIL nest_rti10 act=%h exp=00010", d); else n_pass++;
    pulse_irq(15'h0004);
    repeat (4) begin
      tick();
      n_total++; if (bus.VECTOR !== 4'd0) $display("FAIL nest_blocked act=%0d exp=0", bus.VECTOR); else n_pass++;
    end
    n_total++; if (bus.INT_PEND !== 1'b0) $display("FAIL nest_int_pend act=%0b exp=0", bus.INT_PEND); else n_pass++;
    port_read(1, d);
    n_total++; if (d !== 18'h00004) $display("FAIL nest_pend act=%h exp=00004", d); else n_pass++;
    do_rti();
    n_total++; if (bus.VECTOR !== 4'd0) $display("FAIL nest_rti_edge act=%0d exp=0", bus.VECTOR); else n_pass++;
    tick();
    n_total++; if (bus.VECTOR !== 4'd3) $display("FAIL nest_vec3 act=%0d exp=3", bus.VECTOR); else n_pass++;
    do_ack();
    do_rti();
    port_read(2, d);
    n_total++; if (d !== 18'd0) $display("FAIL nest_insvc_empty act=%h exp=0", d); else n_pass++;
  endtask

  task automatic test_priority();
    logic [17:0] d;
    int exp_v[3] = '{12, 7, 3};
    port_write(0, 18'h00844);
    pulse_irq(15'h0844);
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin do_ack(); do_rti(); tick(); end
      n_total++; if (bus.VECTOR !== 4'(exp_v[i])) $display("FAIL prio_order%0d act=%0d exp=%0d", i, bus.VECTOR, exp_v[i]); else n_pass++;
    end
    do_ack();
    do_rti();
    port_read(1, d);
    n_total++; if (d !== 18'd0) $display("FAIL prio_pend_empty act=%h exp=0", d); else n_pass++;
  endtask

  task automatic test_mask_drop();
    logic [17:0] d;
    port_write(0, 18'h00040);
    pulse_irq(15'h0040);
    tick();
    n_total++; if (bus.VECTOR !== 4'd7) $display("FAIL drop_vec7 act=%0d exp=7", bus.VECTOR); else n_pass++;
    port_write(0, 18'h00000);
    n_total++; if (bus.VECTOR !== 4'd0) $display("FAIL drop_masked act=%0d exp=0", bus.VECTOR); else n_pass++;
    port_read(1, d);
    n_total++; if (d !== 18'h00040) $display("FAIL drop_pend_kept act=%h exp=00040", d); else n_pass++;
    port_write(0, 18'h00040);
    tick();
    n_total++; if (bus.VECTOR !== 4'd7) $display("FAIL drop_reenable act=%0d exp=7", bus.VECTOR); else n_pass++;
    do_ack();
    do_rti();
  endtask

  task automatic test_w1c_rti();
    logic [17:0] d;
    bus.IRQ = 15'h0008;
    bus.PORT_WR = 1'b1; bus.ADRS = BASE + 18'd1; bus.DATAOUT = 18'h00008;
    tick();
    bus.PORT_WR = 1'b0; bus.ADRS = '0; bus.DATAOUT = '0;
    port_read(1, d);
    n_total++; if (d !== 18'h00008) $display("FAIL w1c_set_wins act=%h exp=00008", d); else n_pass++;
    port_write(1, 18'h00008);
    port_read(1, d);
    n_total++; if (d !== 18'd0) $display("FAIL w1c_clear act=%h exp=0", d); else n_pass++;
    bus.IRQ = '0;
    do_rti();
    port_read(2, d);
    n_total++; if (d !== 18'd0) $display("FAIL rti_empty act=%h exp=0", d); else n_pass++;
    n_total++; if (bus.VECTOR !== 4'd0) $display("FAIL rti_empty_vec act=%0d exp=0", bus.VECTOR); else n_pass++;
    bus.PORT_WR = 1'b1; bus.PORT_RD = 1'b1; bus.ADRS = BASE; bus.DATAOUT = 18'h3FFFF;
    #1;
    n_total++; if (bus.RDATA !== 18'h00040) $display("FAIL rw_old_value act=%h exp=00040", bus.RDATA); else n_pass++;
    tick();
    bus.PORT_WR = 1'b0; bus.PORT_RD = 1'b0; bus.DATAOUT = '0;
    port_read(0, d);
    n_total++; if (d !== 18'h07FFF) $display("FAIL mask_hi_bits act=%h exp=07fff", d); else n_pass++;
    port_read(3, d);
    n_total++; if (d !== 18'h00001) $display("FAIL ctrl_read act=%h exp=00001", d); else n_pass++;
    port_read(-1, d);
    n_total++; if (d !== 18'd0) $display("FAIL read_below act=%h exp=0", d); else n_pass++;
    port_read(4, d);
    n_total++; if (d !== 18'd0) $display("FAIL read_above act=%h exp=0", d); else n_pass++;
  endtask

  task automatic test_reset_present();
    logic [17:0] d;
    port_write(0, 18'h00100);
    pulse_irq(15'h0100);
    tick();
    n_total++; if (bus.VECTOR !== 4'd9) $display("FAIL rst_pre_vec act=%0d exp=9", bus.VECTOR); else n_pass++;
    rst_n = 1'b0;
    tick();
    n_total++; if (bus.VECTOR !== 4'd0) $display("FAIL rst_vec act=%0d exp=0", bus.VECTOR); else n_pass++;
    rst_n = 1'b1;
    for (int off = 0; off < 4; off++) begin
      port_read(off, d);
      n_total++; if (d !== 18'd0) $display("FAIL rst_reg%0d act=%h exp=0", off, d); else n_pass++;
    end
    n_total++; if (bus.INT_PEND !== 1'b0) $display("FAIL rst_int_pend act=%0b exp=0", bus.INT_PEND); else n_pass++;
  endtask

  task automatic test_random();
    int          op;
    logic [17:0] data;
    port_write(3, 18'h00001);
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int b = 0; b < 15; b++) if ($urandom_range(7) == 0) bus.IRQ[b] = ~bus.IRQ[b];
      bus.INT_ACK  = ((m_vec != 0) && ($urandom_range(3) == 0)) || ($urandom_range(15) == 0);
      bus.RTI_DONE = ($urandom_range(7) == 0);
      op = int'($urandom_range(7));
      bus.PORT_WR = (op == 0) || (op == 2);
      bus.PORT_RD = (op == 1) || (op == 2);
      bus.ADRS    = BASE + 18'($urandom_range(5)) - 18'd1;
      data        = 18'($urandom);
      if (bus.ADRS == BASE + 18'd3) data[0] = ($urandom_range(4) != 0);
      bus.DATAOUT = data;
      #1;
      n_total++; if (bus.INT_PEND !== (m_best(m_pend, m_mask, m_gie, m_level()) != 0))
        $display("FAIL rand_int_pend cyc=%0d act=%0b", cyc, bus.INT_PEND); else n_pass++;
      if (bus.PORT_RD) begin
        n_total++; if (bus.RDATA !== m_read(bus.ADRS))
          $display("FAIL rand_rdata cyc=%0d act=%h exp=%h", cyc, bus.RDATA, m_read(bus.ADRS)); else n_pass++;
      end
      tick();
      n_total++; if (bus.VECTOR !== 4'(m_vec))
        $display("FAIL rand_vector cyc=%0d act=%0d exp=%0d", cyc, bus.VECTOR, m_vec); else n_pass++;
    end
    bus.IRQ = '0; bus.INT_ACK = 1'b0; bus.RTI_DONE = 1'b0;
    bus.PORT_WR = 1'b0; bus.PORT_RD = 1'b0; bus.ADRS = '0; bus.DATAOUT = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.IRQ = '0; bus.INT_ACK = 1'b0; bus.RTI_DONE = 1'b0;
    bus.PORT_WR = 1'b0; bus.PORT_RD = 1'b0; bus.ADRS = '0; bus.DATAOUT = '0;
    test_reset();
    test_basic();
    test_nesting();
    test_priority();
    test_mask_drop();
    test_w1c_rti();
    test_reset_present();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
